// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the two-port SDRAM read arbiter.
package sdram_arb_pkg;

  localparam int SDRAM_ADDR_WIDTH = 23;
  localparam int SDRAM_DATA_WIDTH = 32;
  localparam int BURST_LEN_WIDTH  = 9;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ISSUE  = 2'd1,
    ARB_STREAM = 2'd2
  } arb_state_e;

  localparam logic PORT_VID = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/sdram_read_arbiter_latch.sv
// Per-port request latch: captures a request pulse, drops zero-length requests,
// flags overruns and clears (or refills) on grant.
module arb_request_latch
  import sdram_arb_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        request,
  input  logic [SDRAM_ADDR_WIDTH-1:0] address,
  input  logic [BURST_LEN_WIDTH-1:0]  burst_length,
  input  logic                        grant,
  output logic                        valid,
  output logic [SDRAM_ADDR_WIDTH-1:0] latched_address,
  output logic [BURST_LEN_WIDTH-1:0]  latched_length,
  output logic                        overrun
);

  logic nonzero_request;
  logic accept;

  assign nonzero_request = request && (burst_length != '0);
  // A grant frees the slot in the same cycle, so a pulse then refills it.
  assign accept = nonzero_request && (!valid || grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid           <= 1'b0;
      latched_address <= '0;
      latched_length  <= '0;
      overrun         <= 1'b0;
    end else begin
      if (accept) begin
        valid           <= 1'b1;
        latched_address <= address;
        latched_length  <= burst_length;
      end else if (grant) begin
        valid <= 1'b0;
      end
      if (nonzero_request && valid && !grant)
        overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_read_arbiter.sv
// Two-port SDRAM read arbiter (video has priority, no preemption).
// Optional beat timeout enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_read_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        vid_rd_request,
  input  logic [SDRAM_ADDR_WIDTH-1:0] vid_rd_address,
  input  logic [BURST_LEN_WIDTH-1:0]  vid_rd_burst_length,
  output logic                        vid_rd_available,
  output logic [SDRAM_DATA_WIDTH-1:0] vid_rd_data,
  input  logic                        aux_rd_request,
  input  logic [SDRAM_ADDR_WIDTH-1:0] aux_rd_address,
  input  logic [BURST_LEN_WIDTH-1:0]  aux_rd_burst_length,
  output logic                        aux_rd_available,
  output logic [SDRAM_DATA_WIDTH-1:0] aux_rd_data,
  output logic                        vid_overrun,
  output logic                        aux_overrun,
  output logic                        timeout,
  output logic                        busy,
  output logic                        rd_request,
  output logic [SDRAM_ADDR_WIDTH-1:0] rd_address,
  output logic [BURST_LEN_WIDTH-1:0]  rd_burst_length,
  input  logic                        rd_available,
  input  logic [SDRAM_DATA_WIDTH-1:0] rd_data
);

  localparam logic [1:0] IDLE   = ARB_IDLE;
  localparam logic [1:0] ISSUE  = ARB_ISSUE;
  localparam logic [1:0] STREAM = ARB_STREAM;

  logic [1:0]                  state;
  logic                        cur_port;
  logic [BURST_LEN_WIDTH-1:0]  beat_cnt;
  logic [SDRAM_ADDR_WIDTH-1:0] rd_addr_q;
  logic [BURST_LEN_WIDTH-1:0]  rd_len_q;

  logic                        vid_valid, aux_valid;
  logic [SDRAM_ADDR_WIDTH-1:0] vid_addr_q, aux_addr_q;
  logic [BURST_LEN_WIDTH-1:0]  vid_len_q, aux_len_q;
  logic                        any_valid, last_beat, abort, burst_end;
  logic                        grant_now, vid_grant, aux_grant;
  logic                        stream_vid, stream_aux;

  arb_request_latch u_vid_latch (
    .clk             (clk),
    .reset           (reset),
    .request         (vid_rd_request),
    .address         (vid_rd_address),
    .burst_length    (vid_rd_burst_length),
    .grant           (vid_grant),
    .valid           (vid_valid),
    .latched_address (vid_addr_q),
    .latched_length  (vid_len_q),
    .overrun         (vid_overrun)
  );

  arb_request_latch u_aux_latch (
    .clk             (clk),
    .reset           (reset),
    .request         (aux_rd_request),
    .address         (aux_rd_address),
    .burst_length    (aux_rd_burst_length),
    .grant           (aux_grant),
    .valid           (aux_valid),
    .latched_address (aux_addr_q),
    .latched_length  (aux_len_q),
    .overrun         (aux_overrun)
  );

  assign any_valid = vid_valid || aux_valid;
  assign last_beat = (state == STREAM) && rd_available && (beat_cnt == rd_len_q - 9'd1);
  assign burst_end = last_beat || abort;
  // Grants happen from IDLE or on the closing cycle of a burst, giving back-to-back issue.
  assign grant_now = any_valid && ((state == IDLE) || burst_end);
  assign vid_grant = grant_now && vid_valid;
  assign aux_grant = grant_now && !vid_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_port  <= PORT_VID;
      beat_cnt  <= '0;
      rd_addr_q <= '0;
      rd_len_q  <= '0;
    end else begin
      if (grant_now) begin
        cur_port  <= vid_valid ? PORT_VID : PORT_AUX;
        rd_addr_q <= vid_valid ? vid_addr_q : aux_addr_q;
        rd_len_q  <= vid_valid ? vid_len_q : aux_len_q;
      end
      case (state)
        IDLE:    if (any_valid) state <= ISSUE;
        ISSUE: begin
          state    <= STREAM;
          beat_cnt <= '0;
        end
        STREAM: begin
          if (burst_end)
            state <= any_valid ? ISSUE : IDLE;
          else if (rd_available)
            beat_cnt <= beat_cnt + 9'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] idle_cnt;
  logic            timeout_q;

  // Counts silent STREAM cycles; the abort cycle itself already reports timeout.
  assign abort   = (state == STREAM) && !rd_available && (idle_cnt == TO_LAST);
  assign timeout = timeout_q || abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state != STREAM) || rd_available)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;
      if (abort)
        timeout_q <= 1'b1;
    end
  end
`else
  assign abort   = 1'b0;
  assign timeout = 1'b0;
`endif

  assign stream_vid = (state == STREAM) && (cur_port == PORT_VID);
  assign stream_aux = (state == STREAM) && (cur_port == PORT_AUX);

  assign vid_rd_available = stream_vid && rd_available;
  assign vid_rd_data      = vid_rd_available ? rd_data : '0;
  assign aux_rd_available = stream_aux && rd_available;
  assign aux_rd_data      = aux_rd_available ? rd_data : '0;

  assign busy            = (state != IDLE);
  assign rd_request      = (state == ISSUE);
  assign rd_address      = rd_addr_q;
  assign rd_burst_length = rd_len_q;

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Self-checking bench for sdram_read_arbiter: vector table plus directed sequences.
module tb_sdram_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vid_rd_request, aux_rd_request, rd_available;
  logic [22:0] vid_rd_address, aux_rd_address, rd_address;
  logic [8:0]  vid_rd_burst_length, aux_rd_burst_length, rd_burst_length;
  logic        vid_rd_available, aux_rd_available;
  logic [31:0] vid_rd_data, aux_rd_data, rd_data;
  logic        vid_overrun, aux_overrun, timeout, busy, rd_request;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  sdram_read_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk                 (clk),
    .reset               (reset),
    .vid_rd_request      (vid_rd_request),
    .vid_rd_address      (vid_rd_address),
    .vid_rd_burst_length (vid_rd_burst_length),
    .vid_rd_available    (vid_rd_available),
    .vid_rd_data         (vid_rd_data),
    .aux_rd_request      (aux_rd_request),
    .aux_rd_address      (aux_rd_address),
    .aux_rd_burst_length (aux_rd_burst_length),
    .aux_rd_available    (aux_rd_available),
    .aux_rd_data         (aux_rd_data),
    .vid_overrun         (vid_overrun),
    .aux_overrun         (aux_overrun),
    .timeout             (timeout),
    .busy                (busy),
    .rd_request          (rd_request),
    .rd_address          (rd_address),
    .rd_burst_length     (rd_burst_length),
    .rd_available        (rd_available),
    .rd_data             (rd_data)
  );

  typedef struct {
    logic        vid_req;
    logic [22:0] vid_addr;
    logic [8:0]  vid_len;
    logic        aux_req;
    logic [22:0] aux_addr;
    logic [8:0]  aux_len;
    logic        beat;
    logic [31:0] beat_data;
    logic        exp_rd_req;
    logic        exp_busy;
    logic [22:0] exp_rd_addr;
    logic [8:0]  exp_rd_len;
    logic        exp_vid_av;
    logic [31:0] exp_vid_data;
    logic        exp_aux_av;
    logic [31:0] exp_aux_data;
    logic        exp_vid_ov;
    logic        exp_aux_ov;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic vreq, input logic [22:0] vaddr, input logic [8:0] vlen,
                               input logic areq, input logic [22:0] aaddr, input logic [8:0] alen,
                               input logic beat, input logic [31:0] bdata);
    @(posedge clk);
    #1;
    vid_rd_request      = vreq;
    vid_rd_address      = vaddr;
    vid_rd_burst_length = vlen;
    aux_rd_request      = areq;
    aux_rd_address      = aaddr;
    aux_rd_burst_length = alen;
    rd_available        = beat;
    rd_data             = bdata;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 23'h0, 9'd0, 1'b0, 23'h0, 9'd0, 1'b0, 32'h0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, 32'(busy), 32'h0);
    checkOutput({tag, " rd_request"}, 32'(rd_request), 32'h0);
    checkOutput({tag, " rd_address"}, 32'(rd_address), 32'h0);
    checkOutput({tag, " rd_burst_length"}, 32'(rd_burst_length), 32'h0);
    checkOutput({tag, " vid_av"}, 32'(vid_rd_available), 32'h0);
    checkOutput({tag, " aux_av"}, 32'(aux_rd_available), 32'h0);
    checkOutput({tag, " vid_data"}, vid_rd_data, 32'h0);
    checkOutput({tag, " aux_data"}, aux_rd_data, 32'h0);
    checkOutput({tag, " overruns"}, {30'h0, vid_overrun, aux_overrun}, 32'h0);
    checkOutput({tag, " timeout"}, 32'(timeout), 32'h0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idleCycle();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    vid_rd_request = 1'b0; vid_rd_address = '0; vid_rd_burst_length = '0;
    aux_rd_request = 1'b0; aux_rd_address = '0; aux_rd_burst_length = '0;
    rd_available = 1'b0; rd_data = '0;

    // Table: simultaneous requests, discarded ISSUE beat, overrun, refill on grant, zero length.
    //               vreq  vaddr       vlen   areq  aaddr       alen   beat  bdata           rdreq busy  rdaddr      rdlen  vav   vdata           aav   adata         vov   aov
    vecs[0]  = '{1'b1, 23'h000100, 9'd2, 1'b1, 23'h0ABCDE, 9'd3, 1'b0, 32'h0,         1'b0, 1'b0, 23'h0,      9'd0, 1'b0, 32'h0,         1'b0, 32'h0,   1'b0, 1'b0};
    vecs[1]  = '{1'b0, 23'h0,      9'd0, 1'b0, 23'h0,      9'd0, 1'b0, 32'h0,         1'b0, 1'b0, 23'h0,      9'd0, 1'b0, 32'h0,         1'b0, 32'h0,   1'b0, 1'b0};
    vecs[2]  = '{1'b0, 23'h0,      9'd0, 1'b1, 23'h055555, 9'd5, 1'b1, 32'h11,        1'b1, 1'b1, 23'h000100, 9'd2, 1'b0, 32'h0,         1'b0, 32'h0,   1'b0, 1'b0};
    vecs[3]  = '{1'b0, 23'h0,      9'd0, 1'b0, 23'h0,      9'd0, 1'b1, 32'hAAAA0001,  1'b0, 1'b1, 23'h000100, 9'd2, 1'b1, 32'hAAAA0001,  1'b0, 32'h0,   1'b0, 1'b1};
    vecs[4]  = '{1'b0, 23'h0,      9'd0, 1'b1, 23'h033333, 9'd1, 1'b1, 32'hAAAA0002,  1'b0, 1'b1, 23'h000100, 9'd2, 1'b1, 32'hAAAA0002,  1'b0, 32'h0,   1'b0, 1'b1};
    vecs[5]  = '{1'b0, 23'h0,      9'd0, 1'b0, 23'h0,      9'd0, 1'b0, 32'h0,         1'b1, 1'b1, 23'h0ABCDE, 9'd3, 1'b0, 32'h0,         1'b0, 32'h0,   1'b0, 1'b1};
    vecs[6]  = '{1'b0, 23'h0,      9'd0, 1'b0, 23'h0,      9'd0, 1'b0, 32'h0,         1'b0, 1'b1, 23'h0ABCDE, 9'd3, 1'b0, 32'h0,         1'b0, 32'h0,   1'b0, 1'b1};
    vecs[7]  = '{1'b0, 23'h0,      9'd0, 1'b0, 23'h0,      9'd0, 1'b1, 32'hB1,        1'b0, 1'b1, 23'h0ABCDE, 9'd3, 1'b0, 32'h0,         1'b1, 32'hB1,  1'b0, 1'b1};
    vecs[8]  = '{1'b0, 23'h0,      9'd0, 1'b0, 23'h0,      9'd0, 1'b1, 32'hB2,        1'b0, 1'b1, 23'h0ABCDE, 9'd3, 1'b0, 32'h0,         1'b1, 32'hB2,  1'b0, 1'b1};
    vecs[9]  = '{1'b0, 23'h0,      9'd0, 1'b0, 23'h0,      9'd0, 1'b1, 32'hB3,        1'b0, 1'b1, 23'h0ABCDE, 9'd3, 1'b0, 32'h0,         1'b1, 32'hB3,  1'b0, 1'b1};
    vecs[10] = '{1'b0, 23'h0,      9'd0, 1'b0, 23'h0,      9'd0, 1'b1, 32'hDEAD,      1'b1, 1'b1, 23'h033333, 9'd1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b0, 1'b1};
    vecs[11] = '{1'b0, 23'h0,      9'd0, 1'b0, 23'h0,      9'd0, 1'b1, 32'hC1,        1'b0, 1'b1, 23'h033333, 9'd1, 1'b0, 32'h0,         1'b1, 32'hC1,  1'b0, 1'b1};
    vecs[12] = '{1'b0, 23'h0,      9'd0, 1'b1, 23'h000007, 9'd0, 1'b1, 32'hDEAD,      1'b0, 1'b0, 23'h033333, 9'd1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b0, 1'b1};
    vecs[13] = '{1'b0, 23'h0,      9'd0, 1'b0, 23'h0,      9'd0, 1'b0, 32'h0,         1'b0, 1'b0, 23'h033333, 9'd1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b0, 1'b1};
    vecs[14] = '{1'b0, 23'h0,      9'd0, 1'b0, 23'h0,      9'd0, 1'b0, 32'h0,         1'b0, 1'b0, 23'h033333, 9'd1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b0, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].vid_req, vecs[i].vid_addr, vecs[i].vid_len,
                    vecs[i].aux_req, vecs[i].aux_addr, vecs[i].aux_len,
                    vecs[i].beat, vecs[i].beat_data);
      @(negedge clk);
      checkOutput($sformatf("vec%0d rd_request", i), 32'(rd_request), 32'(vecs[i].exp_rd_req));
      checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      checkOutput($sformatf("vec%0d rd_address", i), 32'(rd_address), 32'(vecs[i].exp_rd_addr));
      checkOutput($sformatf("vec%0d rd_burst_length", i), 32'(rd_burst_length), 32'(vecs[i].exp_rd_len));
      checkOutput($sformatf("vec%0d vid_av", i), 32'(vid_rd_available), 32'(vecs[i].exp_vid_av));
      checkOutput($sformatf("vec%0d vid_data", i), vid_rd_data, vecs[i].exp_vid_data);
      checkOutput($sformatf("vec%0d aux_av", i), 32'(aux_rd_available), 32'(vecs[i].exp_aux_av));
      checkOutput($sformatf("vec%0d aux_data", i), aux_rd_data, vecs[i].exp_aux_data);
      checkOutput($sformatf("vec%0d vid_overrun", i), 32'(vid_overrun), 32'(vecs[i].exp_vid_ov));
      checkOutput($sformatf("vec%0d aux_overrun", i), 32'(aux_overrun), 32'(vecs[i].exp_aux_ov));
    end

    // Single 80-word video burst.
    doReset();
    @(negedge clk);
    checkAllZero("reset2");
    applyStimulus(1'b1, 23'h000100, 9'd80, 1'b0, 23'h0, 9'd0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("vid80 t0 rd_request", 32'(rd_request), 32'h0);
    idleCycle();
    @(negedge clk);
    checkOutput("vid80 t1 rd_request", 32'(rd_request), 32'h0);
    idleCycle();
    @(negedge clk);
    checkOutput("vid80 t2 rd_request", 32'(rd_request), 32'h1);
    checkOutput("vid80 rd_address", 32'(rd_address), 32'h100);
    checkOutput("vid80 rd_burst_length", 32'(rd_burst_length), 32'd80);
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'b0, 23'h0, 9'd0, 1'b0, 23'h0, 9'd0, 1'b1, 32'h5000_0000 + 32'(i));
      @(negedge clk);
      checkOutput($sformatf("vid80 beat%0d vid_av", i), 32'(vid_rd_available), 32'h1);
      checkOutput($sformatf("vid80 beat%0d vid_data", i), vid_rd_data, 32'h5000_0000 + 32'(i));
      checkOutput($sformatf("vid80 beat%0d aux_av", i), 32'(aux_rd_available), 32'h0);
      checkOutput($sformatf("vid80 beat%0d busy", i), 32'(busy), 32'h1);
    end
    idleCycle();
    @(negedge clk);
    checkOutput("vid80 busy after", 32'(busy), 32'h0);
    checkOutput("vid80 rd_address held", 32'(rd_address), 32'h100);
    checkOutput("vid80 timeout", 32'(timeout), 32'h0);

    // Reset in the middle of a burst.
    applyStimulus(1'b1, 23'h000200, 9'd80, 1'b0, 23'h0, 9'd0, 1'b0, 32'h0);
    idleCycle();
    idleCycle();
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 23'h0, 9'd0, 1'b0, 23'h0, 9'd0, 1'b1, 32'h6000_0000 + 32'(i));
    @(negedge clk);
    checkOutput("midrst beat10 vid_av", 32'(vid_rd_available), 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    rd_data = 32'h6000_000A;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd_data = 32'h6000_000B;
    @(negedge clk);
    checkAllZero("midrst");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 23'h0, 9'd0, 1'b0, 23'h0, 9'd0, 1'b1, 32'h6000_0010 + 32'(i));
      @(negedge clk);
      checkOutput($sformatf("midrst residual%0d vid_av", i), 32'(vid_rd_available), 32'h0);
      checkOutput($sformatf("midrst residual%0d aux_av", i), 32'(aux_rd_available), 32'h0);
      checkOutput($sformatf("midrst residual%0d busy", i), 32'(busy), 32'h0);
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    // Burst stalls after 5 of 8 beats while an aux request waits.
    doReset();
    applyStimulus(1'b1, 23'h000300, 9'd8, 1'b0, 23'h0, 9'd0, 1'b0, 32'h0);
    idleCycle();
    idleCycle();
    applyStimulus(1'b0, 23'h0, 9'd0, 1'b1, 23'h000022, 9'd4, 1'b1, 32'h7000_0000);
    for (int i = 1; i < 5; i++)
      applyStimulus(1'b0, 23'h0, 9'd0, 1'b0, 23'h0, 9'd0, 1'b1, 32'h7000_0000 + 32'(i));
    for (int j = 1; j <= 16; j++) begin
      idleCycle();
      @(negedge clk);
      checkOutput($sformatf("timeout gap%0d timeout", j), 32'(timeout), (j == 16) ? 32'h1 : 32'h0);
      checkOutput($sformatf("timeout gap%0d rd_request", j), 32'(rd_request), 32'h0);
    end
    idleCycle();
    @(negedge clk);
    checkOutput("timeout aux rd_request", 32'(rd_request), 32'h1);
    checkOutput("timeout aux rd_address", 32'(rd_address), 32'h22);
    checkOutput("timeout aux rd_burst_length", 32'(rd_burst_length), 32'd4);
    checkOutput("timeout sticky", 32'(timeout), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
